// File: rtl/cmd_proc.sv
// ---------------------------------------------------------------------------
// cmd_proc -- command processor between a UART wrapper and a small register
// file. A 16-bit command word is accepted from upstream and decoded.
// WRITE stores a byte, READ returns a byte, DELAY waits a programmable number
// of cycles, and any other opcode is rejected. A one-byte response is then
// handed back to the UART wrapper.
//
// Ports
//   clk          in   1   system clock, all state on rising edge
//   rst_n        in   1   asynchronous active-low reset
//   cmd          in  16   command word {opcode[15:12], ign[11:10], addr[9:8], data[7:0]}
//   cmd_rdy      in   1   level, new command available
//   clr_cmd_rdy  out  1   one-cycle pulse acknowledging the command upstream
//   resp         out  8   response byte, stable from RESP until back in IDLE
//   send_resp    out  1   one-cycle pulse, start response transmission
//   resp_sent    in   1   response transmission finished (honoured in WAIT_SENT only)
//   busy         out  1   high in every state except IDLE
//   regs         out 32   register file {reg3, reg2, reg1, reg0}
//
// Parameters
//   ACK  positive response byte
//   NAK  unknown-opcode response byte
// ---------------------------------------------------------------------------
module cmd_proc #(
    parameter logic [7:0] ACK = 8'hA5,
    parameter logic [7:0] NAK = 8'hEE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic [7:0]  resp,
    output logic        send_resp,
    input  logic        resp_sent,
    output logic        busy,
    output logic [31:0] regs
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EXEC      = 3'd1,
        DELAY     = 3'd2,
        RESP      = 3'd3,
        WAIT_SENT = 3'd4
    } state_t;

    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_READ  = 4'h2;
    localparam logic [3:0] OP_DELAY = 4'h3;

    state_t      state_r;
    logic [15:0] cmd_r;
    logic [7:0]  cnt_r;
    logic [31:0] regs_r;
    logic [7:0]  resp_r;
    logic        clr_r;
    logic        send_r;
    logic        busy_r;

    // Field decode of the latched command word.
    logic [3:0]  opcode_s;
    logic [1:0]  addr_s;
    logic [7:0]  data_s;
    logic [4:0]  bit_idx_s;
    logic        unused_bits_s;

    assign opcode_s      = cmd_r[15:12];
    assign addr_s        = cmd_r[9:8];
    assign data_s        = cmd_r[7:0];
    assign bit_idx_s     = {addr_s, 3'b000};
    // cmd[11:10] carry no meaning; they are latched but never decoded.
    assign unused_bits_s = ^cmd_r[11:10];

    // Command FSM with all outputs and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cmd_r   <= 16'h0000;
            cnt_r   <= 8'h00;
            regs_r  <= 32'h0000_0000;
            resp_r  <= 8'h00;
            clr_r   <= 1'b0;
            send_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            // Pulses default low; the branches below raise them for one cycle.
            clr_r  <= 1'b0;
            send_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cmd_rdy) begin
                        cmd_r   <= cmd;
                        clr_r   <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= EXEC;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                EXEC: begin
                    case (opcode_s)
                        OP_WRITE: begin
                            regs_r[bit_idx_s +: 8] <= data_s;
                            resp_r  <= ACK;
                            send_r  <= 1'b1;
                            state_r <= RESP;
                        end
                        OP_READ: begin
                            resp_r  <= regs_r[bit_idx_s +: 8];
                            send_r  <= 1'b1;
                            state_r <= RESP;
                        end
                        OP_DELAY: begin
                            cnt_r   <= data_s;
                            state_r <= DELAY;
                        end
                        default: begin
                            resp_r  <= NAK;
                            send_r  <= 1'b1;
                            state_r <= RESP;
                        end
                    endcase
                end
                DELAY: begin
                    // Counter value 0 is checked before decrementing, so a
                    // load of N spends N+1 cycles here.
                    if (cnt_r == 8'h00) begin
                        resp_r  <= ACK;
                        send_r  <= 1'b1;
                        state_r <= RESP;
                    end else begin
                        cnt_r   <= cnt_r - 8'h01;
                    end
                end
                RESP: begin
                    state_r <= WAIT_SENT;
                end
                WAIT_SENT: begin
                    if (resp_sent) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT_SENT;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign clr_cmd_rdy = clr_r;
    assign send_resp   = send_r;
    assign busy        = busy_r;
    assign resp        = resp_r;
    assign regs        = regs_r;

endmodule

// File: doc/cmd_proc.md
CMD_PROC -- requirements
Module: cmd_proc

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: cmd  in  16  command word from the UART wrapper; valid while cmd_rdy=1.
REQ-004 SHALL have ports: cmd_rdy  in  1  level, new command available.
REQ-005 SHALL have ports: clr_cmd_rdy  out  1  one-cycle pulse, acknowledges and clears cmd_rdy upstream.
REQ-006 SHALL have ports: resp  out  8  response byte to the UART wrapper.
REQ-007 SHALL have ports: send_resp  out  1  one-cycle pulse, start response transmission.
REQ-008 SHALL have ports: resp_sent  in  1  pulse or level, response transmission finished.
REQ-009 SHALL have ports: busy  out  1  high in every state except IDLE.
REQ-010 SHALL have ports: regs  out  32  register file, {reg3,reg2,reg1,reg0}, 8 bits each.
REQ-011 Parameters: ACK, default 8'hA5, positive response; NAK, default 8'hEE, unknown-opcode response.

Function
REQ-012 Command fields SHALL be: opcode = cmd[15:12]; addr = cmd[9:8], with cmd[11:10] ignored; data = cmd[7:0].
REQ-013 Opcodes SHALL be: 4'h1 WRITE, 4'h2 READ, 4'h3 DELAY; all others are NAK.
REQ-014 FSM states SHALL be IDLE, EXEC, DELAY, RESP, WAIT_SENT.
REQ-015 IDLE: when cmd_rdy=1 is sampled at edge k, cmd SHALL be latched into an internal register at edge k, and the state SHALL go to EXEC.
REQ-016 clr_cmd_rdy SHALL be high for exactly the one cycle following edge k (registered), and low at all other times.
REQ-017 EXEC, WRITE: reg[addr] <= data; resp <= ACK; next state RESP.
REQ-018 EXEC, READ: resp <= reg[addr], sampled before any write in the same cycle; next state RESP.
REQ-019 EXEC, DELAY: an 8-bit down-counter SHALL load data; next state DELAY.
REQ-020 EXEC, NAK opcode: resp <= NAK; registers unchanged; next state RESP.
REQ-021 DELAY state: the counter SHALL decrement each cycle while nonzero; when the counter = 0, resp <= ACK and next state RESP.
- data=0: exactly 1 cycle in DELAY.
- data=N: N+1 cycles in DELAY.
REQ-022 RESP state SHALL last one cycle; send_resp=1 in that cycle only; next state WAIT_SENT.
REQ-023 Latency, non-DELAY: cmd_rdy sampled at edge k -> send_resp high in cycle k+2 (EXEC = k+1).
REQ-024 Latency, DELAY: send_resp high in cycle k+3+data.
REQ-025 resp SHALL hold stable from the RESP cycle until the return to IDLE.
REQ-026 WAIT_SENT: resp_sent=1 sampled -> IDLE on the next edge; otherwise remain, with no timeout.
REQ-027 resp_sent sampled in any state other than WAIT_SENT SHALL be ignored.
REQ-028 cmd_rdy while busy=1 SHALL be ignored: no clr_cmd_rdy and no latch. The pending command SHALL be accepted on the first IDLE cycle that sees cmd_rdy=1, allowing back-to-back commands with 1 idle cycle minimum.
REQ-029 cmd_rdy still high in the cycle in which clr_cmd_rdy is asserted (upstream clear latency) SHALL NOT cause a second acceptance; the FSM is already in EXEC.
REQ-030 Register writes SHALL occur only in EXEC for WRITE; regs SHALL reflect the new value from the cycle after EXEC.
REQ-031 addr SHALL always be in range (2 bits); no wrap handling is needed beyond truncation of cmd[11:10].

Reset
REQ-032 rst_n=0 SHALL asynchronously force: state IDLE; regs=32'h0; resp=8'h00; counter=0; latched cmd=16'h0000; clr_cmd_rdy=0; send_resp=0; busy=0.
REQ-033 Reset asserted mid-operation (EXEC, DELAY, RESP, WAIT_SENT) SHALL abort with no further pulses; a pending cmd_rdy SHALL be accepted normally after release.
REQ-034 The first cycle after rst_n deasserts SHALL be able to accept a command.

Verification
REQ-035 WRITE then READ: cmd=16'h1103 (reg1<=8'h03) -> resp=A5, regs[15:8]=8'h03; then cmd=16'h2100 -> resp=8'h03; other regs remain 8'h00.
REQ-036 Handshake timing: cmd_rdy rises at edge k -> clr_cmd_rdy high exactly in cycle k+1; send_resp high exactly in cycle k+2, one cycle wide; busy low again one cycle after resp_sent.
REQ-037 DELAY: cmd=16'h3005 -> send_resp in cycle k+8; cmd=16'h3000 -> send_resp in cycle k+3; resp=A5 in both cases.
REQ-038 NAK: cmd=16'hF2FF -> resp=EE, regs unchanged; opcode 4'h0 -> resp=EE.
REQ-039 Busy ignore: cmd_rdy held high during WAIT_SENT for 20 cycles with resp_sent withheld -> no clr_cmd_rdy until IDLE, then accepted exactly once; resp_sent during DELAY has no effect.
REQ-040 Reset mid-DELAY: cmd=16'h30FF, rst_n low at count 100 -> regs=0, no send_resp, busy=0; after release, cmd=16'h2000 -> resp=00.
